// File: rtl/axi_wr_arbiter.sv
// Two-requester arbiter for a single AXI4 write channel: one AW -> W burst -> B per grant.
// Define AXI_WR_RR_EN for round-robin tie-break; otherwise requester 0 wins every tie.
module axi_wr_arbiter #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*LEN_WIDTH-1:0]  req_len,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]              req_wvalid,
  output logic [1:0]              req_wready,
  output logic [1:0]              done,
  output logic [1:0]              done_resp,
  output logic [ID_WIDTH-1:0]     awid_m_inf,
  output logic [ADDR_WIDTH-1:0]   awaddr_m_inf,
  output logic [2:0]              awsize_m_inf,
  output logic [1:0]              awburst_m_inf,
  output logic [LEN_WIDTH-1:0]    awlen_m_inf,
  output logic                    awvalid_m_inf,
  input  logic                    awready_m_inf,
  output logic [DATA_WIDTH-1:0]   wdata_m_inf,
  output logic                    wlast_m_inf,
  output logic                    wvalid_m_inf,
  input  logic                    wready_m_inf,
  input  logic [ID_WIDTH-1:0]     bid_m_inf,
  input  logic [1:0]              bresp_m_inf,
  input  logic                    bvalid_m_inf,
  output logic                    bready_m_inf
);

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [1:0]              done_q, done_d;
  logic [1:0]              resp_q, resp_d;
  logic                    grant;
  logic                    own_wvalid;
  logic [DATA_WIDTH-1:0]   own_wdata;
  logic                    beat_last;

  // The response ID is never needed: only one transaction is ever outstanding.
  logic unused_bid;
  assign unused_bid = ^bid_m_inf;

`ifdef AXI_WR_RR_EN
  logic last_q, last_d;

  always_comb begin
    if (req_valid == 2'b11) begin
      grant = ~last_q;
    end else begin
      grant = ~req_valid[0];
    end
  end
`else
  assign grant = ~req_valid[0];
`endif

  assign own_wvalid = owner_q ? req_wvalid[1] : req_wvalid[0];
  assign own_wdata  = owner_q ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign beat_last  = (cnt_q == len_q);

  assign awid_m_inf    = {{(ID_WIDTH-1){1'b0}}, owner_q};
  assign awaddr_m_inf  = addr_q;
  assign awlen_m_inf   = len_q;
  assign awsize_m_inf  = 3'b001;
  assign awburst_m_inf = 2'b01;
  assign done          = done_q;
  assign done_resp     = resp_q;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    done_d        = 2'b00;
    resp_d        = 2'b00;
    req_ready     = 2'b00;
    req_wready    = 2'b00;
    awvalid_m_inf = 1'b0;
    wvalid_m_inf  = 1'b0;
    wdata_m_inf   = '0;
    wlast_m_inf   = 1'b0;
    bready_m_inf  = 1'b0;
`ifdef AXI_WR_RR_EN
    last_d        = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if ((req_valid != 2'b00) && !rst) begin
          req_ready[grant] = 1'b1;
          owner_d          = grant;
          addr_d           = grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : req_addr[ADDR_WIDTH-1:0];
          len_d            = grant ? req_len[2*LEN_WIDTH-1:LEN_WIDTH] : req_len[LEN_WIDTH-1:0];
          state_d          = StAw;
`ifdef AXI_WR_RR_EN
          last_d           = grant;
`endif
        end
      end
      StAw: begin
        awvalid_m_inf = 1'b1;
        if (awready_m_inf) begin
          state_d = StW;
          cnt_d   = '0;
        end
      end
      StW: begin
        wvalid_m_inf        = own_wvalid;
        wdata_m_inf         = own_wdata;
        wlast_m_inf         = beat_last;
        req_wready[owner_q] = wready_m_inf;
        if (own_wvalid && wready_m_inf) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (beat_last) begin
            state_d = StB;
          end
        end
      end
      StB: begin
        bready_m_inf = 1'b1;
        if (bvalid_m_inf) begin
          state_d         = StIdle;
          done_d[owner_q] = 1'b1;
          resp_d          = bresp_m_inf;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 2'b00;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
    end
  end

`ifdef AXI_WR_RR_EN
  // Starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: transaction-phase model checked every cycle plus directed scenarios.
// Honours AXI_WR_RR_EN the same way the design does.
module tb_axi_wr_arbiter;
  localparam int unsigned IW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_ready, req_wvalid, req_wready, done, done_resp;
  logic [2*AW-1:0] req_addr;
  logic [2*LW-1:0] req_len;
  logic [2*DW-1:0] req_wdata;
  logic [IW-1:0]   awid_m_inf, bid_m_inf;
  logic [AW-1:0]   awaddr_m_inf;
  logic [2:0]      awsize_m_inf;
  logic [1:0]      awburst_m_inf, bresp_m_inf;
  logic [LW-1:0]   awlen_m_inf;
  logic            awvalid_m_inf, awready_m_inf;
  logic [DW-1:0]   wdata_m_inf;
  logic            wlast_m_inf, wvalid_m_inf, wready_m_inf;
  logic            bvalid_m_inf, bready_m_inf;

  axi_wr_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .req_wdata(req_wdata), .req_wvalid(req_wvalid), .req_wready(req_wready),
    .done(done), .done_resp(done_resp),
    .awid_m_inf(awid_m_inf), .awaddr_m_inf(awaddr_m_inf), .awsize_m_inf(awsize_m_inf),
    .awburst_m_inf(awburst_m_inf), .awlen_m_inf(awlen_m_inf), .awvalid_m_inf(awvalid_m_inf),
    .awready_m_inf(awready_m_inf),
    .wdata_m_inf(wdata_m_inf), .wlast_m_inf(wlast_m_inf), .wvalid_m_inf(wvalid_m_inf),
    .wready_m_inf(wready_m_inf),
    .bid_m_inf(bid_m_inf), .bresp_m_inf(bresp_m_inf), .bvalid_m_inf(bvalid_m_inf),
    .bready_m_inf(bready_m_inf)
  );

  int total = 0;
  int bad   = 0;

  // Scenario configuration, written only by the main sequence.
  int unsigned   cfg_issued[2];
  logic [AW-1:0] cfg_addr[2];
  logic [LW-1:0] cfg_len[2];
  int unsigned   cfg_aw_delay;
  bit            cfg_w_toggle;
  int unsigned   cfg_wv_gap;
  logic [1:0]    cfg_bresp;

  // Model state: which phase of a transaction the channel is in, and what was granted.
  int            m_phase;
  int            m_owner;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  int            m_beats;
  int            m_last;
  bit            m_done_pend;
  int            m_done_owner;
  logic [1:0]    m_done_resp;

  // Observations of the DUT for the directed checks.
  int            ncyc = 0;
  int            obs_grants[$];
  int            obs_awids[$];
  logic [AW-1:0] obs_awaddr;
  logic [LW-1:0] obs_awlen;
  int            obs_grant_cyc = 0;
  int            obs_aw_rise = 0;
  int            obs_aw_wait = 0;
  int            obs_beats = 0;
  int            obs_wlast_cnt = 0;
  int            obs_wlast_at = 0;
  int            obs_done_cnt = 0;
  logic [1:0]    obs_done;
  logic [1:0]    obs_done_resp;
  bit            awv_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (req_valid == 2'b11) begin
`ifdef AXI_WR_RR_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return req_valid[0] ? 0 : 1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_addr = '0; m_len = '0; m_beats = 0; m_last = 1;
    m_done_pend = 1'b0; m_done_owner = 0; m_done_resp = 2'b00; awv_prev = 1'b0;
  endtask

  task automatic check_cycle();
    logic [1:0] e_rr;
    logic [1:0] e_wr;
    int g;
    ncyc++;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_req_wready", req_wready, 0);
      chk("rst_awvalid", awvalid_m_inf, 0);
      chk("rst_wvalid", wvalid_m_inf, 0);
      chk("rst_wlast", wlast_m_inf, 0);
      chk("rst_bready", bready_m_inf, 0);
      chk("rst_done", done, 0);
      chk("rst_done_resp", done_resp, 0);
      chk("rst_awaddr", awaddr_m_inf, 0);
      chk("rst_awlen", awlen_m_inf, 0);
      chk("rst_awid", awid_m_inf, 0);
      chk("rst_wdata", wdata_m_inf, 0);
      chk("rst_awsize", awsize_m_inf, 3'b001);
      chk("rst_awburst", awburst_m_inf, 2'b01);
      model_reset();
    end else begin
      g = model_grant();
      e_rr = 2'b00;
      if (m_phase == 0 && req_valid != 2'b00) e_rr[g] = 1'b1;
      chk("req_ready", req_ready, e_rr);
      chk("awvalid", awvalid_m_inf, m_phase == 1);
      chk("awaddr", awaddr_m_inf, m_addr);
      chk("awlen", awlen_m_inf, m_len);
      chk("awid", awid_m_inf, m_owner);
      chk("awsize", awsize_m_inf, 3'b001);
      chk("awburst", awburst_m_inf, 2'b01);
      chk("wvalid", wvalid_m_inf, (m_phase == 2) ? req_wvalid[m_owner] : 1'b0);
      if (m_phase == 2) chk("wdata", wdata_m_inf, req_wdata[m_owner*DW +: DW]);
      chk("wlast", wlast_m_inf, (m_phase == 2) && (m_beats == int'(m_len)));
      e_wr = 2'b00;
      if (m_phase == 2) e_wr[m_owner] = wready_m_inf;
      chk("req_wready", req_wready, e_wr);
      chk("bready", bready_m_inf, m_phase == 3);
      chk("done", done, m_done_pend ? (2'b01 << m_done_owner) : 2'b00);
      if (m_done_pend) chk("done_resp", done_resp, m_done_resp);

      if (req_ready[0]) obs_grants.push_back(0);
      else if (req_ready[1]) obs_grants.push_back(1);
      if (req_ready != 2'b00) obs_grant_cyc = ncyc;
      if (awvalid_m_inf && !awv_prev) obs_aw_rise = ncyc;
      if (awvalid_m_inf && !awready_m_inf) obs_aw_wait++;
      if (awvalid_m_inf && awready_m_inf) begin
        obs_awids.push_back(int'(awid_m_inf));
        obs_awaddr = awaddr_m_inf;
        obs_awlen  = awlen_m_inf;
      end
      if (wvalid_m_inf && wready_m_inf) begin
        obs_beats++;
        if (wlast_m_inf) begin
          obs_wlast_cnt++;
          obs_wlast_at = obs_beats;
        end
      end
      if (done != 2'b00) begin
        obs_done_cnt++;
        obs_done = done;
        obs_done_resp = done_resp;
      end
      awv_prev = awvalid_m_inf;

      m_done_pend = 1'b0;
      case (m_phase)
        0: if (req_valid != 2'b00) begin
          m_owner = g;
          m_addr  = req_addr[g*AW +: AW];
          m_len   = req_len[g*LW +: LW];
          m_last  = g;
          m_phase = 1;
        end
        1: if (awready_m_inf) begin
          m_phase = 2;
          m_beats = 0;
        end
        2: if (req_wvalid[m_owner] && wready_m_inf) begin
          if (m_beats == int'(m_len)) m_phase = 3;
          else m_beats++;
        end
        default: if (bvalid_m_inf) begin
          m_phase      = 0;
          m_done_pend  = 1'b1;
          m_done_owner = m_owner;
          m_done_resp  = bresp_m_inf;
        end
      endcase
    end
  endtask

  // Requester and AXI slave behaviour: sample at negedge, drive just after posedge.
  initial begin : bfm
    int unsigned gnt_cnt[2];
    int unsigned beat[2];
    int unsigned aw_cnt;
    int unsigned bcyc;
    bit          b_pend;
    logic        s_rst, s_awv, s_awr, s_wv, s_wr, s_wl, s_bv, s_br;
    logic [1:0]  s_rr, s_rwr, s_rwv;
    gnt_cnt = '{0, 0};
    beat = '{0, 0};
    aw_cnt = 0; bcyc = 0; b_pend = 1'b0;
    req_valid = '0; req_addr = '0; req_len = '0; req_wdata = '0; req_wvalid = '0;
    awready_m_inf = 1'b0; wready_m_inf = 1'b0; bvalid_m_inf = 1'b0;
    bresp_m_inf = 2'b00; bid_m_inf = '0;
    forever begin
      @(negedge clk);
      s_rst = rst; s_rr = req_ready; s_rwr = req_wready; s_rwv = req_wvalid;
      s_awv = awvalid_m_inf; s_awr = awready_m_inf; s_wv = wvalid_m_inf;
      s_wr = wready_m_inf; s_wl = wlast_m_inf; s_bv = bvalid_m_inf; s_br = bready_m_inf;
      @(posedge clk);
      #1;
      bcyc++;
      if (s_rst) begin
        for (int i = 0; i < 2; i++) begin
          gnt_cnt[i] = cfg_issued[i];
          beat[i] = 0;
        end
        aw_cnt = 0;
        b_pend = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (s_rr[i]) begin
            gnt_cnt[i]++;
            beat[i] = 0;
          end
          if (s_rwr[i] && s_rwv[i]) beat[i]++;
        end
        if (s_awv && s_awr) aw_cnt = 0;
        else if (s_awv) aw_cnt++;
        if (s_wv && s_wr && s_wl) b_pend = 1'b1;
        if (s_bv && s_br) b_pend = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = gnt_cnt[i] < cfg_issued[i];
        req_addr[i*AW +: AW] = cfg_addr[i] + AW'(gnt_cnt[i] * 32'h100);
        req_len[i*LW +: LW] = cfg_len[i];
        req_wdata[i*DW +: DW] = DW'(i * 32'h8000 + (gnt_cnt[i] % 8) * 32'h100 + beat[i]);
        req_wvalid[i] = (cfg_wv_gap == 0) || (bcyc % cfg_wv_gap != 0);
      end
      awready_m_inf = aw_cnt >= cfg_aw_delay;
      wready_m_inf = cfg_w_toggle ? bcyc[0] : 1'b1;
      bvalid_m_inf = b_pend;
      bresp_m_inf = cfg_bresp;
    end
  end

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (obs_done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, obs_done_cnt >= target, 1);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2;
  endtask

  initial begin : main
    int g0, a0, d0, b0, wl0, aw0, n;
    int exp_order[4];
    rst = 1'b1;
    cfg_issued = '{0, 0};
    cfg_addr = '{32'h0000_1000, 32'h0000_2000};
    cfg_len = '{7'd3, 7'd0};
    cfg_aw_delay = 0; cfg_w_toggle = 1'b0; cfg_wv_gap = 0; cfg_bresp = 2'b00;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        check_cycle();
      end
    join_none
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2;

    // Single request from requester 0, len 3.
    g0 = obs_grants.size(); d0 = obs_done_cnt; b0 = obs_beats; wl0 = obs_wlast_cnt;
    cfg_issued[0] += 1;
    wait_done(d0 + 1, 100, "single_done");
    chk("single_grant_cnt", obs_grants.size() - g0, 1);
    if (obs_grants.size() > g0) chk("single_owner", obs_grants[g0], 0);
    chk("single_aw_latency", obs_aw_rise - obs_grant_cyc, 1);
    chk("single_awaddr", obs_awaddr, 32'h0000_1000);
    chk("single_awlen", obs_awlen, 3);
    chk("single_beats", obs_beats - b0, 4);
    chk("single_wlast_cnt", obs_wlast_cnt - wl0, 1);
    chk("single_wlast_beat", obs_wlast_at - b0, 4);
    chk("single_done_val", obs_done, 2'b01);
    chk("single_done_resp", obs_done_resp, 2'b00);

    // Simultaneous requests, both held for two transactions, len 0.
    do_reset();
`ifdef AXI_WR_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif
    cfg_len = '{7'd0, 7'd0};
    g0 = obs_grants.size(); a0 = obs_awids.size(); d0 = obs_done_cnt;
    cfg_issued[0] += 2;
    cfg_issued[1] += 2;
    wait_done(d0 + 4, 200, "tie_done");
    chk("tie_grant_cnt", obs_grants.size() - g0, 4);
    if (obs_grants.size() >= g0 + 4 && obs_awids.size() >= a0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tie_order%0d", i), obs_grants[g0 + i], exp_order[i]);
        chk($sformatf("tie_awid%0d", i), obs_awids[a0 + i], exp_order[i]);
      end
    end

    // Backpressure: awready after 5 waiting cycles, wready toggling, wvalid gaps.
    cfg_len[0] = 7'd5; cfg_aw_delay = 5; cfg_w_toggle = 1'b1; cfg_wv_gap = 3;
    d0 = obs_done_cnt; b0 = obs_beats; wl0 = obs_wlast_cnt; aw0 = obs_aw_wait;
    cfg_issued[0] += 1;
    wait_done(d0 + 1, 300, "bp_done");
    chk("bp_aw_wait", obs_aw_wait - aw0, 5);
    chk("bp_beats", obs_beats - b0, 6);
    chk("bp_wlast_beat", obs_wlast_at - b0, 6);
    chk("bp_wlast_cnt", obs_wlast_cnt - wl0, 1);
    cfg_aw_delay = 0; cfg_w_toggle = 1'b0; cfg_wv_gap = 0;

    // Maximum burst on requester 1.
    cfg_len[1] = 7'd127;
    d0 = obs_done_cnt; b0 = obs_beats; wl0 = obs_wlast_cnt;
    cfg_issued[1] += 1;
    wait_done(d0 + 1, 400, "max_done");
    chk("max_beats", obs_beats - b0, 128);
    chk("max_wlast_cnt", obs_wlast_cnt - wl0, 1);
    chk("max_wlast_beat", obs_wlast_at - b0, 128);
    chk("max_awlen", obs_awlen, 127);

    // Error response on requester 1.
    cfg_len[1] = 7'd1; cfg_bresp = 2'b10;
    d0 = obs_done_cnt;
    cfg_issued[1] += 1;
    wait_done(d0 + 1, 100, "err_done");
    chk("err_done_val", obs_done, 2'b10);
    chk("err_done_resp", obs_done_resp, 2'b10);
    cfg_bresp = 2'b00;

    // Reset at beat 2 of 4, then a fresh request.
    cfg_len[0] = 7'd3;
    d0 = obs_done_cnt; b0 = obs_beats; wl0 = obs_wlast_cnt;
    cfg_issued[0] += 1;
    n = 0;
    while (obs_beats - b0 < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_beat2", obs_beats - b0, 2);
    do_reset();
    repeat (3) @(negedge clk);
    chk("mid_no_done", obs_done_cnt - d0, 0);
    chk("mid_no_wlast", obs_wlast_cnt - wl0, 0);
    #2;
    d0 = obs_done_cnt; b0 = obs_beats;
    cfg_issued[0] += 1;
    wait_done(d0 + 1, 100, "fresh_done");
    chk("fresh_done_val", obs_done, 2'b01);
    chk("fresh_beats", obs_beats - b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
